// File: rtl/back_end_pkg.sv
// back_end_pkg
//   Types and widths shared by the back-end writeback path.
//   - ptag_t / robtag_t / data_t : physical tag, ROB tag and result value
//   - cdb_pkt_t                  : one result as it travels to the CDB
package back_end_pkg;

    localparam int PTAG_W = 6;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef logic [PTAG_W-1:0] ptag_t;
    typedef logic [ROB_W-1:0]  robtag_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic    regwr;
        ptag_t   pd;
        robtag_t tag;
        data_t   data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo
//   Small per-source result queue feeding the CDB arbiter.
//   Pointers carry one wrap bit above the index so that full and empty
//   are told apart without a separate counter.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous clear of all entries
//   push, pkt_in  enqueue (caller only pushes while ready)
//   ready         not full, derived from registered pointers only
//   pop           dequeue head (caller only pops while not empty)
//   pkt_out       current head entry (combinational read)
//   empty         no entries held
module cdb_result_fifo
    import back_end_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  cdb_pkt_t pkt_in,
    output logic     ready,
    input  logic     pop,
    output cdb_pkt_t pkt_out,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    cdb_pkt_t    mem [DEPTH];

    // Same index with opposite wrap bit means every entry is occupied.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign ready   = !((wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]));
    // The head is needed in the same cycle it is granted, so the read is
    // combinational; the storage is tiny and maps to distributed RAM.
    assign pkt_out = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= pkt_in;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Writeback network between the execution units and the CDB/ROB. Every
//   source owns a small result FIFO; each cycle up to N_CDB non-empty
//   sources are granted round-robin onto registered CDB slots.
// Optional build macro
//   CDB_BYPASS_EN : an empty source's fresh offer may be granted directly
//                   (1-cycle latency, never occupies a FIFO entry).
//                   Undefined: every result goes through its FIFO (2 cycles).
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   flush                           synchronous back-end flush
//   src_valid/src_ready             per-source offer / FIFO can accept
//   src_regwr/pd/tag/data           per-source result payload
//   cdb_valid/regwr/pd/tag/data     registered broadcast slots
//   cdb_src                         index of the source granted per slot
// The DATA_W/PTAG_W/ROB_W parameters must match back_end_pkg.
module cdb_arbiter
    import back_end_pkg::*;
#(
    parameter int N_SRC  = 5,
    parameter int N_CDB  = 2,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int PTAG_W = 6,
    parameter int ROB_W  = 6,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [N_SRC-1:0]               src_valid,
    output logic [N_SRC-1:0]               src_ready,
    input  logic [N_SRC-1:0]               src_regwr,
    input  logic [N_SRC-1:0][PTAG_W-1:0]   src_pd,
    input  logic [N_SRC-1:0][ROB_W-1:0]    src_tag,
    input  logic [N_SRC-1:0][DATA_W-1:0]   src_data,
    output logic [N_CDB-1:0]               cdb_valid,
    output logic [N_CDB-1:0]               cdb_regwr,
    output logic [N_CDB-1:0][PTAG_W-1:0]   cdb_pd,
    output logic [N_CDB-1:0][ROB_W-1:0]    cdb_tag,
    output logic [N_CDB-1:0][DATA_W-1:0]   cdb_data,
    output logic [N_CDB-1:0][SRC_W-1:0]    cdb_src
);

    typedef struct packed {
        logic [N_SRC-1:0]            grant;
        logic [N_CDB-1:0]            slot_vld;
        logic [N_CDB-1:0][SRC_W-1:0] slot_src;
        logic [SRC_W-1:0]            next_rr;
    } pick_t;

    // Rotating N_CDB-of-N_SRC picker: scan from rr onwards, hand the k-th
    // requester to slot k, and point rr just past the last one granted.
    function automatic pick_t pick_slots(input logic [N_SRC-1:0] req,
                                         input logic [SRC_W-1:0] rr);
        pick_t p;
        int    n;
        int    rot;
        p         = '0;
        p.next_rr = rr;
        n         = 0;
        for (int k = 0; k < N_SRC; k++) begin
            rot = int'(rr) + k;
            if (rot >= N_SRC) rot = rot - N_SRC;
            for (int i = 0; i < N_SRC; i++) begin
                if (i == rot && req[i] && n < N_CDB) begin
                    p.grant[i] = 1'b1;
                    for (int j = 0; j < N_CDB; j++) begin
                        if (j == n) begin
                            p.slot_vld[j] = 1'b1;
                            p.slot_src[j] = SRC_W'(i);
                        end
                    end
                    p.next_rr = (i == N_SRC-1) ? '0 : SRC_W'(i+1);
                    n         = n + 1;
                end
            end
        end
        return p;
    endfunction

    cdb_pkt_t                    in_pkt   [N_SRC];
    cdb_pkt_t                    head_pkt [N_SRC];
    cdb_pkt_t                    slot_pkt [N_CDB];
    cdb_pkt_t                    cdb_pkt_reg [N_CDB];
    logic [N_SRC-1:0]            fifo_empty;
    logic [N_SRC-1:0]            fifo_ready;
    logic [N_SRC-1:0]            req;
    logic [N_SRC-1:0]            bypass;
    logic [N_SRC-1:0]            push;
    logic [N_SRC-1:0]            pop;
    logic [SRC_W-1:0]            rr_ptr_reg;
    logic [N_CDB-1:0]            cdb_valid_reg;
    logic [N_CDB-1:0][SRC_W-1:0] cdb_src_reg;
    pick_t                       pick;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign in_pkt[gi] = {src_regwr[gi], src_pd[gi], src_tag[gi], src_data[gi]};

            cdb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .push    (push[gi]),
                .pkt_in  (in_pkt[gi]),
                .ready   (fifo_ready[gi]),
                .pop     (pop[gi]),
                .pkt_out (head_pkt[gi]),
                .empty   (fifo_empty[gi])
            );
        end
    endgenerate

`ifdef CDB_BYPASS_EN
    // An empty FIFO can still compete using this cycle's offer.
    assign req    = ~fifo_empty | src_valid;
    assign bypass = pick.grant & fifo_empty;
`else
    assign req    = ~fifo_empty;
    assign bypass = '0;
`endif

    assign pick      = pick_slots(req, rr_ptr_reg);
    // Ready depends only on stored state, never on this cycle's grant.
    assign src_ready = fifo_ready;
    assign push      = src_valid & fifo_ready & ~bypass & {N_SRC{~flush}};
    assign pop       = pick.grant & ~fifo_empty & {N_SRC{~flush}};

    always_comb begin
        for (int j = 0; j < N_CDB; j++) begin
            slot_pkt[j] = '0;
            for (int i = 0; i < N_SRC; i++) begin
                if (pick.slot_src[j] == SRC_W'(i))
                    slot_pkt[j] = bypass[i] ? in_pkt[i] : head_pkt[i];
            end
        end
    end

    // Idle slots keep their payload; only the valid bit drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= '0;
            cdb_src_reg   <= '0;
            for (int j = 0; j < N_CDB; j++) cdb_pkt_reg[j] <= '0;
        end else if (flush) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= '0;
        end else begin
            rr_ptr_reg    <= pick.next_rr;
            cdb_valid_reg <= pick.slot_vld;
            for (int j = 0; j < N_CDB; j++) begin
                if (pick.slot_vld[j]) begin
                    cdb_pkt_reg[j] <= slot_pkt[j];
                    cdb_src_reg[j] <= pick.slot_src[j];
                end
            end
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_src   = cdb_src_reg;

    generate
        for (gi = 0; gi < N_CDB; gi++) begin : g_out
            assign cdb_regwr[gi] = cdb_pkt_reg[gi].regwr;
            assign cdb_pd[gi]    = cdb_pkt_reg[gi].pd;
            assign cdb_tag[gi]   = cdb_pkt_reg[gi].tag;
            assign cdb_data[gi]  = cdb_pkt_reg[gi].data;
        end
    endgenerate

`ifndef SYNTHESIS
    // Sources never stall, so an offer to a full FIFO would be lost.
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_chk
            a_no_offer_when_full: assert property (@(posedge clk) disable iff (rst)
                !(src_valid[gi] && !src_ready[gi]));
        end
    endgenerate
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N_SRC = 5;
    localparam int N_CDB = 2;
    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic        regwr;
        logic [5:0]  pd;
        logic [5:0]  tag;
        logic [31:0] data;
    } mpkt_t;

    typedef struct {
        int    src;
        mpkt_t p;
    } obs_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush = 1'b0;
    logic [N_SRC-1:0]        src_valid = '0;
    logic [N_SRC-1:0]        src_ready;
    logic [N_SRC-1:0]        src_regwr = '0;
    logic [N_SRC-1:0][5:0]   src_pd = '0;
    logic [N_SRC-1:0][5:0]   src_tag = '0;
    logic [N_SRC-1:0][31:0]  src_data = '0;
    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB-1:0]        cdb_regwr;
    logic [N_CDB-1:0][5:0]   cdb_pd;
    logic [N_CDB-1:0][5:0]   cdb_tag;
    logic [N_CDB-1:0][31:0]  cdb_data;
    logic [N_CDB-1:0][2:0]   cdb_src;

    cdb_arbiter #(.N_SRC(N_SRC), .N_CDB(N_CDB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready), .src_regwr(src_regwr),
        .src_pd(src_pd), .src_tag(src_tag), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_regwr(cdb_regwr), .cdb_pd(cdb_pd),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int    checks = 0;
    int    errors = 0;
    mpkt_t mq [N_SRC][$];
    int    m_rr = 0;
    logic [N_CDB-1:0] e_valid;
    mpkt_t e_pkt [N_CDB];
    int    e_src [N_CDB];
    bit    e_reset;
    obs_t  obs_q [$];
    int    step_no = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic mpkt_t cur_pkt(input int i);
        return {src_regwr[i], src_pd[i], src_tag[i], src_data[i]};
    endfunction

    function automatic bit m_ready(input int i);
        return mq[i].size() < DEPTH;
    endfunction

    function automatic bit m_empty();
        for (int i = 0; i < N_SRC; i++) if (mq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N_SRC; i++) mq[i].delete();
        m_rr = 0;
    endtask

    // Reference: per-source queues, rotating scan for up to N_CDB requesters.
    task automatic model_edge();
        bit byp [N_SRC];
        int n;
        int idx;
        int rr0;
        bit rq;
        for (int i = 0; i < N_SRC; i++) byp[i] = 1'b0;
        e_reset = 1'b0;
        e_valid = '0;
        if (rst) begin
            m_clear();
            e_reset = 1'b1;
            for (int j = 0; j < N_CDB; j++) begin
                e_pkt[j] = '0;
                e_src[j] = 0;
            end
        end else if (flush) begin
            m_clear();
        end else begin
            n   = 0;
            rr0 = m_rr;
            for (int k = 0; k < N_SRC; k++) begin
                idx = (rr0 + k) % N_SRC;
                rq  = mq[idx].size() > 0;
`ifdef CDB_BYPASS_EN
                rq  = rq || src_valid[idx];
`endif
                if (rq && n < N_CDB) begin
                    if (mq[idx].size() > 0) e_pkt[n] = mq[idx].pop_front();
                    else begin
                        e_pkt[n] = cur_pkt(idx);
                        byp[idx] = 1'b1;
                    end
                    e_src[n]   = idx;
                    e_valid[n] = 1'b1;
                    n++;
                    m_rr = (idx + 1) % N_SRC;
                end
            end
            for (int i = 0; i < N_SRC; i++)
                if (src_valid[i] && !byp[i]) mq[i].push_back(cur_pkt(i));
        end
    endtask

    task automatic step();
        if (!rst)
            for (int i = 0; i < N_SRC; i++)
                chk($sformatf("src_ready%0d", i), 64'(src_ready[i]), 64'(m_ready(i)));
        model_edge();
        @(posedge clk);
        #1;
        step_no++;
        for (int j = 0; j < N_CDB; j++) begin
            chk($sformatf("cdb_valid%0d", j), 64'(cdb_valid[j]), 64'(e_valid[j]));
            if (e_valid[j] || e_reset) begin
                chk($sformatf("cdb_pkt%0d", j),
                    64'({cdb_regwr[j], cdb_pd[j], cdb_tag[j], cdb_data[j]}), 64'(e_pkt[j]));
                chk($sformatf("cdb_src%0d", j), 64'(cdb_src[j]), 64'(e_src[j]));
            end
            if (cdb_valid[j])
                obs_q.push_back('{int'(cdb_src[j]), {cdb_regwr[j], cdb_pd[j], cdb_tag[j], cdb_data[j]}});
        end
    endtask

    task automatic idle_inputs();
        src_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int n = 0; n < 20; n++) begin
            if (m_empty()) break;
            step();
        end
        step();
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N_SRC; i++) begin
            src_regwr[i] = 1'($urandom);
            src_pd[i]    = 6'($urandom);
            src_tag[i]   = 6'($urandom_range(8, 63));
            src_data[i]  = $urandom;
        end
    endtask

    initial begin
        int    cnt [N_SRC];
        int    last [N_SRC];
        int    max_gap;
        int    cmin;
        int    cmax;
        int    n3;
        int    sevens;
        bit    saw_full;
        logic [31:0] d3;
        logic [31:0] v3 [$];

        // 1: reset held with offers present
        #1 rst = 1'b1;
        src_valid = '1;
        rand_fields();
        for (int c = 0; c < 3; c++) step();
        src_valid = '0;
        rst = 1'b0;
        #1;
        chk("reset_ready", 64'(src_ready), 64'h1f);
        chk("reset_rr", 64'(dut.rr_ptr_reg), 64'h0);

        // 2: contention, one entry per source
        for (int i = 0; i < N_SRC; i++) begin
            src_regwr[i] = 1'b1;
            src_pd[i]    = 6'(i);
            src_tag[i]   = 6'(8 + i);
            src_data[i]  = 32'h10 + 32'(i);
        end
        src_valid = '1;
        step();
        idle_inputs();
`ifndef CDB_BYPASS_EN
        step();
`endif
        chk("cont_c2_valid", 64'(cdb_valid), 64'h3);
        chk("cont_c2_src0", 64'(cdb_src[0]), 64'h0);
        chk("cont_c2_src1", 64'(cdb_src[1]), 64'h1);
        chk("cont_c2_data0", 64'(cdb_data[0]), 64'h10);
        step();
        chk("cont_c3_valid", 64'(cdb_valid), 64'h3);
        chk("cont_c3_src0", 64'(cdb_src[0]), 64'h2);
        chk("cont_c3_src1", 64'(cdb_src[1]), 64'h3);
        step();
        chk("cont_c4_valid", 64'(cdb_valid), 64'h1);
        chk("cont_c4_src0", 64'(cdb_src[0]), 64'h4);
        chk("cont_c4_data0", 64'(cdb_data[0]), 64'h14);
        chk("cont_rr", 64'(dut.rr_ptr_reg), 64'h0);
        drain();

        // 3: backpressure on src3 while everyone is saturated
        obs_q.delete();
        saw_full = 1'b0;
        d3 = 32'hA;
        for (int c = 0; c < 30; c++) begin
            rand_fields();
            for (int i = 0; i < N_SRC; i++) src_valid[i] = m_ready(i);
            src_data[3] = d3;
            if (!src_ready[3]) saw_full = 1'b1;
            step();
            if (src_valid[3]) d3 = d3 + 1;
        end
        drain();
        chk("bp_ready_dropped", 64'(saw_full), 64'h1);
        v3.delete();
        foreach (obs_q[k]) if (obs_q[k].src == 3) v3.push_back(obs_q[k].p.data);
        n3 = v3.size();
        chk("bp_count_ge3", 64'(n3 >= 3), 64'h1);
        if (n3 >= 3) begin
            chk("bp_order0", 64'(v3[0]), 64'hA);
            chk("bp_order1", 64'(v3[1]), 64'hB);
            chk("bp_order2", 64'(v3[2]), 64'hC);
        end

        // 4: flush with a same-cycle offer
        rand_fields();
        src_valid = 5'b01111;
        step();
        src_valid = 5'b00010;
        src_tag[1] = 6'h07;
        flush = 1'b1;
        step();
        chk("flush_valid", 64'(cdb_valid), 64'h0);
        chk("flush_rr", 64'(dut.rr_ptr_reg), 64'h0);
        idle_inputs();
        obs_q.delete();
        src_valid = 5'b01000;
        src_tag[3] = 6'h08;
        step();
        idle_inputs();
`ifndef CDB_BYPASS_EN
        step();
`endif
        chk("postflush_valid", 64'(cdb_valid), 64'h1);
        chk("postflush_src0", 64'(cdb_src[0]), 64'h3);
        chk("postflush_tag0", 64'(cdb_tag[0]), 64'h08);
        for (int c = 0; c < 4; c++) step();
        sevens = 0;
        foreach (obs_q[k]) if (obs_q[k].p.tag == 6'h07) sevens++;
        chk("flush_tag7_absent", 64'(sevens), 64'h0);
        drain();

        // 5: single result into empty FIFOs
        src_regwr[2] = 1'b1;
        src_pd[2]    = 6'h21;
        src_tag[2]   = 6'h15;
        src_data[2]  = 32'hDEADBEEF;
        src_valid    = 5'b00100;
        step();
        idle_inputs();
`ifndef CDB_BYPASS_EN
        chk("byp_early_valid", 64'(cdb_valid), 64'h0);
        step();
`endif
        chk("byp_valid0", 64'(cdb_valid[0]), 64'h1);
        chk("byp_regwr0", 64'(cdb_regwr[0]), 64'h1);
        chk("byp_pd0", 64'(cdb_pd[0]), 64'h21);
        chk("byp_data0", 64'(cdb_data[0]), 64'hDEADBEEF);
        chk("byp_src0", 64'(cdb_src[0]), 64'h2);
        drain();

        // 6: fairness under continuous offers
        for (int i = 0; i < N_SRC; i++) begin
            cnt[i]  = 0;
            last[i] = -1;
        end
        max_gap = 0;
        for (int c = 0; c < 110; c++) begin
            rand_fields();
            for (int i = 0; i < N_SRC; i++) src_valid[i] = m_ready(i);
            obs_q.delete();
            step();
            if (c >= 10) begin
                foreach (obs_q[k]) begin
                    cnt[obs_q[k].src]++;
                    if (last[obs_q[k].src] >= 0 && c - last[obs_q[k].src] > max_gap)
                        max_gap = c - last[obs_q[k].src];
                    last[obs_q[k].src] = c;
                end
            end
        end
        drain();
        cmin = cnt[0];
        cmax = cnt[0];
        for (int i = 1; i < N_SRC; i++) begin
            if (cnt[i] < cmin) cmin = cnt[i];
            if (cnt[i] > cmax) cmax = cnt[i];
        end
        chk("fair_count_spread_le1", 64'(cmax - cmin <= 1), 64'h1);
        chk("fair_max_gap_le3", 64'(max_gap <= 3), 64'h1);
        chk("fair_total", 64'(cmin * N_SRC <= 200 && cmax * N_SRC >= 200), 64'h1);

        // Random traffic with occasional flush and one mid-run reset
        for (int c = 0; c < 300; c++) begin
            rand_fields();
            for (int i = 0; i < N_SRC; i++) src_valid[i] = m_ready(i) && ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 31) == 0);
            if (c == 150) begin
                rst = 1'b1;
                #1;
                chk("midrst_valid", 64'(cdb_valid), 64'h0);
                chk("midrst_ready", 64'(src_ready), 64'h1f);
                src_valid = '0;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
